// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with committed HI/LO and shadow result registers.
// Executes mult/multu/div/divu (and madd when MDU_MADD_EN is defined), mthi/mtlo and
// mfhi/mflo reads, and raises the D-stage stall for MDU hazards.
// Optional feature macro: MDU_MADD_EN (op 111 = signed multiply-accumulate into {HI,LO}).
// Ports:
//   clk          pipeline clock
//   reset        asynchronous active-low reset
//   E_MD_Op      E-stage MDU op (000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                101 mthi, 110 mtlo, 111 madd/no-op)
//   E_MD_Rd_HI   1 reads HI onto E_MD_Result, 0 reads LO
//   E_RD1/E_RD2  forwarded rs/rt operands
//   D_MD_Use     D-stage instruction uses the MDU
//   E_MD_Busy    multi-cycle operation in flight
//   E_MD_Result  committed HI or LO (combinational read)
//   MD_Stall     D-stage stall request (combinational)
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_MD_Op,
  input  logic        E_MD_Rd_HI,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic        D_MD_Use,
  output logic        E_MD_Busy,
  output logic [31:0] E_MD_Result,
  output logic        MD_Stall
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b111;
`endif

  logic [31:0]      r_hi, r_lo, r_hi_s, r_lo_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_commit;

  logic             w_is_mul, w_is_div, w_start, w_div_signed, w_div_zero;
  logic [63:0]      w_prod_s, w_prod_u, w_shadow;
  logic [31:0]      w_dividend, w_divisor, w_uq, w_ur, w_quo, w_rem;
  logic [CNT_W-1:0] w_start_cnt;

  // Op decode and start qualification
  always_comb begin
    w_is_mul = (E_MD_Op == OP_MULT) || (E_MD_Op == OP_MULTU);
`ifdef MDU_MADD_EN
    if (E_MD_Op == OP_MADD) w_is_mul = 1'b1;
`endif
    w_is_div     = (E_MD_Op == OP_DIV) || (E_MD_Op == OP_DIVU);
    w_start      = (w_is_mul || w_is_div) && !r_busy;
    w_div_signed = (E_MD_Op == OP_DIV);
    w_div_zero   = (E_RD2 == 32'd0);
    w_start_cnt  = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  // Low 64 bits of the product of sign-extended operands is the signed product
  assign w_prod_s = {{32{E_RD1[31]}}, E_RD1} * {{32{E_RD2[31]}}, E_RD2};
  assign w_prod_u = {32'd0, E_RD1} * {32'd0, E_RD2};

  // One unsigned divider on magnitudes; signs restored afterwards. The divisor is
  // forced to 1 on divide-by-zero so the result is defined (it is never committed).
  always_comb begin
    w_dividend = (w_div_signed && E_RD1[31]) ? (32'd0 - E_RD1) : E_RD1;
    w_divisor  = (w_div_signed && E_RD2[31]) ? (32'd0 - E_RD2) : E_RD2;
    if (w_div_zero) w_divisor = 32'd1;
  end

  assign w_uq = w_dividend / w_divisor;
  assign w_ur = w_dividend % w_divisor;

  // Quotient truncates toward zero; remainder takes the dividend's sign.
  // 0x80000000 / -1 yields magnitude 0x80000000 with positive sign, i.e. 0x80000000.
  always_comb begin
    w_quo = w_uq;
    w_rem = w_ur;
    if (w_div_signed) begin
      if (E_RD1[31] ^ E_RD2[31]) w_quo = 32'd0 - w_uq;
      if (E_RD1[31])             w_rem = 32'd0 - w_ur;
    end
  end

  // Shadow result selection
  always_comb begin
    w_shadow = 64'd0;
    case (E_MD_Op)
      OP_MULT:         w_shadow = w_prod_s;
      OP_MULTU:        w_shadow = w_prod_u;
      OP_DIV, OP_DIVU: w_shadow = {w_rem, w_quo};
`ifdef MDU_MADD_EN
      OP_MADD:         w_shadow = {r_hi, r_lo} + w_prod_s;
`endif
      default:         w_shadow = 64'd0;
    endcase
  end

  // HI/LO, shadow and countdown state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_hi_s   <= 32'd0;
      r_lo_s   <= 32'd0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      // Direct writes land immediately, even while busy
      if (E_MD_Op == OP_MTHI) r_hi <= E_RD1;
      if (E_MD_Op == OP_MTLO) r_lo <= E_RD1;
      if (w_start) begin
        r_hi_s   <= w_shadow[63:32];
        r_lo_s   <= w_shadow[31:0];
        r_cnt    <= w_start_cnt;
        r_busy   <= 1'b1;
        r_commit <= !(w_is_div && w_div_zero);
      end else if (r_busy) begin
        r_cnt <= r_cnt - CNT_W'(1);
        // Completion overrides any same-edge mthi/mtlo
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          if (r_commit) begin
            r_hi <= r_hi_s;
            r_lo <= r_lo_s;
          end
        end
      end
    end
  end

  assign E_MD_Busy   = r_busy;
  assign E_MD_Result = E_MD_Rd_HI ? r_hi : r_lo;
  assign MD_Stall    = D_MD_Use && (w_start || r_busy);

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu. Stimulus pushes expected HI/LO reads and busy
// lengths into queues; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_e_mdu;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  E_MD_Op;
  logic        E_MD_Rd_HI;
  logic [31:0] E_RD1, E_RD2;
  logic        D_MD_Use;
  logic        E_MD_Busy;
  logic [31:0] E_MD_Result;
  logic        MD_Stall;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MD_Op(E_MD_Op), .E_MD_Rd_HI(E_MD_Rd_HI),
    .E_RD1(E_RD1), .E_RD2(E_RD2), .D_MD_Use(D_MD_Use),
    .E_MD_Busy(E_MD_Busy), .E_MD_Result(E_MD_Result), .MD_Stall(MD_Stall)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference architectural state
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  int          len_q[$];
  logic        rd_req = 1'b0;
  logic        mon_prev_busy = 1'b0;
  int          mon_bcnt = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: checks requested reads and the length of each busy window
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_prev_busy = 1'b0;
        mon_bcnt = 0;
      end else begin
        if (rd_req) begin
          if (rd_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL read_queue: read requested with no expectation");
          end else begin
            string nm;
            logic [31:0] e;
            e = rd_q.pop_front();
            nm = rd_name_q.pop_front();
            cmp(nm, E_MD_Result, e);
          end
        end
        if (E_MD_Busy) mon_bcnt++;
        else if (mon_prev_busy) begin
          if (len_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL busy_len: unexpected busy window of %0d cycles", mon_bcnt);
          end else begin
            int e;
            e = len_q.pop_front();
            cmp("busy_len", 32'(mon_bcnt), 32'(e));
          end
          mon_bcnt = 0;
        end
        mon_prev_busy = E_MD_Busy;
      end
    end
  end

  // Called just after a posedge; request one read sampled at the coming negedge
  task automatic rd_now(input logic sel, input logic [31:0] exp, input string nm);
    E_MD_Rd_HI = sel;
    rd_q.push_back(exp);
    rd_name_q.push_back(nm);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic check_rd(input string nm);
    @(posedge clk); #1;
    rd_now(1'b1, m_hi, {nm, "_hi"});
    rd_now(1'b0, m_lo, {nm, "_lo"});
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (E_MD_Busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (E_MD_Busy) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles", nm, k);
    end
  endtask

  // Issue one op and advance the reference model once it has architecturally completed
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic        is_start;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
`ifdef MDU_MADD_EN
    is_start = (op >= 3'd1 && op <= 3'd4) || (op == 3'd7);
`else
    is_start = (op >= 3'd1 && op <= 3'd4);
`endif
    if (is_start) len_q.push_back((op == 3'd3 || op == 3'd4) ? int'(DC) : int'(MC));
    @(posedge clk); #1;
    E_MD_Op = op; E_RD1 = a; E_RD2 = b;
    @(posedge clk); #1;
    E_MD_Op = 3'd0;
    cmp($sformatf("busy_after_op%0d", op), 32'(E_MD_Busy), 32'(is_start));
    if (is_start) wait_idle($sformatf("op%0d", op));
    case (op)
      3'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
      3'd3: if (b != 32'd0) begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      3'd4: if (b != 32'd0) begin
        m_lo = a / b; m_hi = a % b;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
`ifdef MDU_MADD_EN
      3'd7: begin p = {m_hi, m_lo} + 64'(sa * sb); {m_hi, m_lo} = p; end
`endif
      default: ;
    endcase
  endtask

  initial begin
    int sc;
    logic [63:0] p;
    reset = 1'b0; E_MD_Op = 3'd0; E_MD_Rd_HI = 1'b0; E_RD1 = 32'd0; E_RD2 = 32'd0; D_MD_Use = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_busy", 32'(E_MD_Busy), 32'd0);
    cmp("reset_result", E_MD_Result, 32'd0);
    reset = 1'b1;
    check_rd("reset");

    // Directed arithmetic
    do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002); check_rd("mult");
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002); check_rd("multu");
    do_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002); check_rd("div_neg");
    do_op(3'd4, 32'h0000_0007, 32'h0000_0000); check_rd("divu_zero");
    do_op(3'd3, 32'h1234_5678, 32'h0000_0000); check_rd("div_zero");
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); check_rd("div_ovf");
    do_op(3'd6, 32'd5, 32'd0);
    do_op(3'd5, 32'd0, 32'd0);
    do_op(3'd7, 32'd3, 32'd4);
    check_rd("op7");

    // mthi while busy lands at once; completion then overwrites both registers
    len_q.push_back(int'(MC));
    @(posedge clk); #1;
    E_MD_Op = 3'd1; E_RD1 = 32'd3; E_RD2 = 32'd5;
    @(posedge clk); #1;
    E_MD_Op = 3'd5; E_RD1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    E_MD_Op = 3'd0;
    rd_now(1'b1, 32'hDEAD_BEEF, "mthi_while_busy");
    wait_idle("mthi_busy");
    m_hi = 32'd0; m_lo = 32'd15;
    check_rd("after_mthi_busy");

    // Stall window across a mult start, then an mfhi right after release
    len_q.push_back(int'(MC));
    sc = 0;
    @(posedge clk); #1;
    E_MD_Op = 3'd1; E_RD1 = 32'h1234_5678; E_RD2 = 32'h9ABC_DEF0; D_MD_Use = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (MD_Stall) sc++;
      else break;
      @(posedge clk); #1;
      E_MD_Op = 3'd0;
    end
    cmp("stall_cycles", 32'(sc), 32'(MC + 1));
    p = 64'(longint'({{32{1'b0}}, 32'h1234_5678}) * longint'({{32{1'b1}}, 32'h9ABC_DEF0}));
    {m_hi, m_lo} = p;
    E_MD_Rd_HI = 1'b1;
    #1;
    cmp("mfhi_after_stall", E_MD_Result, m_hi);
    cmp("stall_released", 32'(MD_Stall), 32'd0);
    D_MD_Use = 1'b0;
    check_rd("stall_mult");

    // Randomized mix against the reference model
    for (int it = 0; it < 40; it++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(1, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op(op, a, b);
      check_rd($sformatf("rand%0d_op%0d", it, op));
    end

    // Reset in the third busy cycle of a div discards the pending result
    @(posedge clk); #1;
    E_MD_Op = 3'd3; E_RD1 = 32'd100; E_RD2 = 32'd7;
    @(posedge clk); #1;
    E_MD_Op = 3'd0;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    D_MD_Use = 1'b1;
    #1;
    cmp("midrst_busy", 32'(E_MD_Busy), 32'd0);
    cmp("midrst_stall", 32'(MD_Stall), 32'd0);
    E_MD_Rd_HI = 1'b1; #1;
    cmp("midrst_hi", E_MD_Result, 32'd0);
    D_MD_Use = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (12) @(posedge clk);
    #1;
    cmp("midrst_no_resume", 32'(E_MD_Busy), 32'd0);
    check_rd("midrst_after");

    repeat (2) @(posedge clk);
    if (len_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL busy_windows: %0d expected busy windows never ended", len_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
